// File: rtl/cam_entry_ctrl.sv
// Management-side controller for the CAM: allocates slots, tracks occupancy and
// keeps a shadow copy of each stored key so that deletes can erase the old key's bits.
module cam_entry_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  cam_write_enable,
  output logic                  cam_erase,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  full
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(ENTRIES);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_DELETE = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_EMPTY  = 2'b01;
  localparam logic [1:0] ST_FULL   = 2'b10;
  localparam logic [1:0] ST_BAD_OP = 2'b11;

  typedef enum logic [2:0] {IDLE, INS_WR, RD, DEL_WR, RESP} state_t;

  state_t state, state_next;

  logic [ENTRIES-1:0]    valid;
  logic [DATA_WIDTH-1:0] shadow [ENTRIES];
  logic [DATA_WIDTH-1:0] shadow_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] free_slot;
  logic                  accept;

  logic                  req_ready_d;
  logic                  rsp_valid_d;
  logic [1:0]            rsp_status_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  cam_write_enable_d;
  logic                  cam_erase_d;
  logic [ADDR_WIDTH-1:0] cam_write_addr_d;
  logic [DATA_WIDTH-1:0] cam_din_d;
  logic [ADDR_WIDTH:0]   free_count_d;

  assign accept = req_valid & req_ready;

  // Lowest-index clear bit wins: scanning downward lets the last hit be the lowest.
  always_comb begin
    free_slot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) free_slot = ADDR_WIDTH'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (req_op)
            OP_INSERT:          state_next = full ? RESP : INS_WR;
            OP_DELETE, OP_READ: state_next = valid[req_addr] ? RD : RESP;
            default:            state_next = RESP;
          endcase
        end
      end
      INS_WR:  state_next = RESP;
      RD:      state_next = (op_q == OP_DELETE) ? DEL_WR : RESP;
      DEL_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything returns to zero unless a
  // state explicitly drives it, so strobes and responses are single-cycle.
  always_comb begin
    req_ready_d        = (state_next == IDLE);
    rsp_valid_d        = 1'b0;
    rsp_status_d       = ST_OK;
    rsp_addr_d         = '0;
    rsp_data_d         = '0;
    cam_write_enable_d = 1'b0;
    cam_erase_d        = 1'b0;
    cam_write_addr_d   = '0;
    cam_din_d          = '0;
    free_count_d       = free_count;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (req_op)
            OP_INSERT: begin
              if (full) begin
                rsp_valid_d  = 1'b1;
                rsp_status_d = ST_FULL;
              end else begin
                cam_write_enable_d = 1'b1;
                cam_write_addr_d   = free_slot;
                cam_din_d          = req_data;
              end
            end
            OP_DELETE, OP_READ: begin
              if (!valid[req_addr]) begin
                rsp_valid_d  = 1'b1;
                rsp_status_d = ST_EMPTY;
                rsp_addr_d   = req_addr;
              end
            end
            default: begin
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_BAD_OP;
            end
          endcase
        end
      end
      INS_WR: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = addr_q;
        if (free_count != '0) free_count_d = free_count - COUNT_ONE;
      end
      RD: begin
        if (op_q == OP_DELETE) begin
          cam_write_enable_d = 1'b1;
          cam_erase_d        = 1'b1;
          cam_write_addr_d   = addr_q;
          cam_din_d          = shadow_q;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_data_d  = shadow_q;
        end
      end
      DEL_WR: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = addr_q;
        rsp_data_d  = shadow_q;
        if (free_count != COUNT_MAX) free_count_d = free_count + COUNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_status       <= ST_OK;
      rsp_addr         <= '0;
      rsp_data         <= '0;
      cam_write_enable <= 1'b0;
      cam_erase        <= 1'b0;
      cam_write_addr   <= '0;
      cam_din          <= '0;
      free_count       <= COUNT_MAX;
      full             <= 1'b0;
    end else begin
      req_ready        <= req_ready_d;
      rsp_valid        <= rsp_valid_d;
      rsp_status       <= rsp_status_d;
      rsp_addr         <= rsp_addr_d;
      rsp_data         <= rsp_data_d;
      cam_write_enable <= cam_write_enable_d;
      cam_erase        <= cam_erase_d;
      cam_write_addr   <= cam_write_addr_d;
      cam_din          <= cam_din_d;
      free_count       <= free_count_d;
      full             <= (free_count_d == '0);
    end
  end

  // Request capture and occupancy bitmap; the captured slot is the allocated
  // one for inserts and the requested one otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      addr_q <= '0;
      data_q <= '0;
      op_q   <= OP_INSERT;
    end else begin
      if (accept) begin
        addr_q <= (req_op == OP_INSERT) ? free_slot : req_addr;
        data_q <= req_data;
        op_q   <= req_op;
      end
      if (state == INS_WR) valid[addr_q] <= 1'b1;
      if (state == DEL_WR) valid[addr_q] <= 1'b0;
    end
  end

  // NOTE: the shadow RAM is deliberately not reset; the valid bitmap is the only
  // authority on which entries hold meaningful keys.
  // The read address follows req_addr while idle so the key is ready in RD.
  always_ff @(posedge clk) begin
    if (state == INS_WR) shadow[addr_q] <= data_q;
    shadow_q <= shadow[(state == IDLE) ? req_addr : addr_q];
  end

endmodule
